// File: rtl/axi4l2wb_bridge.sv
// AXI4-Lite slave to pipelined Wishbone B4 master bridge.
// Single-entry AW/W/AR holding registers, read/write arbitration, one outstanding WB cycle, watchdog.
module axi4l2wb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // AXI4-Lite slave
   input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
   input  logic                    s_awvalid_i,
   output logic                    s_awready_o,
   input  logic [DATA_WIDTH-1:0]   s_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
   input  logic                    s_wvalid_i,
   output logic                    s_wready_o,
   output logic [1:0]              s_bresp_o,
   output logic                    s_bvalid_o,
   input  logic                    s_bready_i,
   input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
   input  logic                    s_arvalid_i,
   output logic                    s_arready_o,
   output logic [DATA_WIDTH-1:0]   s_rdata_o,
   output logic [1:0]              s_rresp_o,
   output logic                    s_rvalid_o,
   input  logic                    s_rready_i,
   // Wishbone B4 pipelined master
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic                    wb_stall_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WB_REQ   = 2'd1;
   localparam logic [1:0] S_WB_WAIT  = 2'd2;
   localparam logic [1:0] S_AXI_RESP = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]            state_q,   state_d;
   logic                  aw_full_q, aw_full_d;
   logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
   logic                  w_full_q,  w_full_d;
   logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
   logic [SEL_W-1:0]      wstrb_q,   wstrb_d;
   logic                  ar_full_q, ar_full_d;
   logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
   logic                  last_wr_q, last_wr_d;
   logic                  cyc_q,     cyc_d;
   logic                  stb_q,     stb_d;
   logic                  we_q,      we_d;
   logic [ADDR_WIDTH-1:0] adr_q,     adr_d;
   logic [DATA_WIDTH-1:0] dat_q,     dat_d;
   logic [SEL_W-1:0]      sel_q,     sel_d;
   logic                  bvalid_q,  bvalid_d;
   logic                  rvalid_q,  rvalid_d;
   logic [1:0]            resp_q,    resp_d;
   logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
   logic [TO_W-1:0]       wd_cnt_q,  wd_cnt_d;

   logic wr_pend, pick_wr, term_ok, wd_expire, done, done_ok;

   assign wr_pend   = aw_full_q && w_full_q;
   assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   // Termination is only meaningful once the slave has taken the request.
   assign term_ok   = (state_q == S_WB_WAIT) || ((state_q == S_WB_REQ) && !wb_stall_i);
   assign done_ok   = term_ok && wb_ack_i && !wb_err_i;
   assign done      = (term_ok && (wb_ack_i || wb_err_i)) || wd_expire;

   // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      aw_full_d = aw_full_q;
      awaddr_d  = awaddr_q;
      w_full_d  = w_full_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      ar_full_d = ar_full_q;
      araddr_d  = araddr_q;
      last_wr_d = last_wr_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      bvalid_d  = bvalid_q;
      rvalid_d  = rvalid_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      wd_cnt_d  = '0;
      pick_wr   = 1'b0;

      if (s_awvalid_i && !aw_full_q) begin
         aw_full_d = 1'b1;
         awaddr_d  = s_awaddr_i;
      end
      if (s_wvalid_i && !w_full_q) begin
         w_full_d = 1'b1;
         wdata_d  = s_wdata_i;
         wstrb_d  = s_wstrb_i;
      end
      if (s_arvalid_i && !ar_full_q) begin
         ar_full_d = 1'b1;
         araddr_d  = s_araddr_i;
      end

      case (state_q)
         S_IDLE: begin
            if (wr_pend || ar_full_q) begin
               // On a tie, serve the kind that did not go last.
               pick_wr   = wr_pend && (!ar_full_q || !last_wr_q);
               state_d   = S_WB_REQ;
               cyc_d     = 1'b1;
               stb_d     = 1'b1;
               we_d      = pick_wr;
               last_wr_d = pick_wr;
               if (pick_wr) begin
                  adr_d     = awaddr_q;
                  dat_d     = wdata_q;
                  sel_d     = wstrb_q;
                  aw_full_d = 1'b0;
                  w_full_d  = 1'b0;
               end else begin
                  adr_d     = araddr_q;
                  dat_d     = '0;
                  sel_d     = '1;
                  ar_full_d = 1'b0;
               end
            end
         end
         S_WB_REQ, S_WB_WAIT: begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
            if (done) begin
               state_d  = S_AXI_RESP;
               cyc_d    = 1'b0;
               stb_d    = 1'b0;
               bvalid_d = we_q;
               rvalid_d = !we_q;
               resp_d   = done_ok ? RESP_OKAY : RESP_SLVERR;
               rdata_d  = (done_ok && !we_q) ? wb_dat_i : '0;
            end else if ((state_q == S_WB_REQ) && !wb_stall_i) begin
               state_d = S_WB_WAIT;
               stb_d   = 1'b0;
            end
         end
         S_AXI_RESP: begin
            if ((bvalid_q && s_bready_i) || (rvalid_q && s_rready_i)) begin
               state_d  = S_IDLE;
               bvalid_d = 1'b0;
               rvalid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         aw_full_q <= 1'b0;
         awaddr_q  <= '0;
         w_full_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         ar_full_q <= 1'b0;
         araddr_q  <= '0;
         last_wr_q <= 1'b0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         resp_q    <= RESP_OKAY;
         rdata_q   <= '0;
         wd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         aw_full_q <= aw_full_d;
         awaddr_q  <= awaddr_d;
         w_full_q  <= w_full_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         ar_full_q <= ar_full_d;
         araddr_q  <= araddr_d;
         last_wr_q <= last_wr_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         wd_cnt_q  <= wd_cnt_d;
      end
   end

   assign s_awready_o = !aw_full_q;
   assign s_wready_o  = !w_full_q;
   assign s_arready_o = !ar_full_q;
   assign s_bvalid_o  = bvalid_q;
   assign s_bresp_o   = resp_q;
   assign s_rvalid_o  = rvalid_q;
   assign s_rresp_o   = resp_q;
   assign s_rdata_o   = rdata_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign wb_we_o     = we_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_axi4l2wb_bridge.sv
// Directed bench for axi4l2wb_bridge: writes, reads, stall, error, watchdog, arbitration, reset.
// The Wishbone slave is driven by hand, cycle by cycle, with a watchdog of 8 cycles.
module tb_axi4l2wb_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] s_awaddr_i = '0;
   logic        s_awvalid_i = 1'b0;
   logic        s_awready_o;
   logic [31:0] s_wdata_i = '0;
   logic [3:0]  s_wstrb_i = '0;
   logic        s_wvalid_i = 1'b0;
   logic        s_wready_o;
   logic [1:0]  s_bresp_o;
   logic        s_bvalid_o;
   logic        s_bready_i = 1'b0;
   logic [31:0] s_araddr_i = '0;
   logic        s_arvalid_i = 1'b0;
   logic        s_arready_o;
   logic [31:0] s_rdata_o;
   logic [1:0]  s_rresp_o;
   logic        s_rvalid_o;
   logic        s_rready_i = 1'b0;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stall_i = 1'b0;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;
   logic [31:0] wb_dat_i = '0;

   int n_assert = 0;
   int n_fail   = 0;

   axi4l2wb_bridge #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .s_awaddr_i (s_awaddr_i),
      .s_awvalid_i(s_awvalid_i),
      .s_awready_o(s_awready_o),
      .s_wdata_i  (s_wdata_i),
      .s_wstrb_i  (s_wstrb_i),
      .s_wvalid_i (s_wvalid_i),
      .s_wready_o (s_wready_o),
      .s_bresp_o  (s_bresp_o),
      .s_bvalid_o (s_bvalid_o),
      .s_bready_i (s_bready_i),
      .s_araddr_i (s_araddr_i),
      .s_arvalid_i(s_arvalid_i),
      .s_arready_o(s_arready_o),
      .s_rdata_o  (s_rdata_o),
      .s_rresp_o  (s_rresp_o),
      .s_rvalid_o (s_rvalid_o),
      .s_rready_i (s_rready_i),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_sel_o   (wb_sel_o),
      .wb_stall_i (wb_stall_i),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .wb_dat_i   (wb_dat_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic        exp_we;
      logic [31:0] exp_adr;

      // Reset state
      tick();
      tick();
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_we", wb_we_o, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_sel", wb_sel_o, 0);
      chk("rst_bvalid", s_bvalid_o, 0);
      chk("rst_rvalid", s_rvalid_o, 0);
      chk("rst_bresp", s_bresp_o, 0);
      chk("rst_rdata", s_rdata_o, 0);
      chk("rst_awready", s_awready_o, 1);
      chk("rst_wready", s_wready_o, 1);
      chk("rst_arready", s_arready_o, 1);
      rst_i = 1'b0;
      tick();

      // T1: AW and W together, slave acks one cycle after accept
      s_awvalid_i = 1; s_awaddr_i = 32'h10;
      s_wvalid_i = 1; s_wdata_i = 32'hDEADBEEF; s_wstrb_i = 4'hF;
      tick();
      chk("t1_awready_full", s_awready_o, 0);
      chk("t1_wready_full", s_wready_o, 0);
      chk("t1_no_cyc_yet", wb_cyc_o, 0);
      s_awvalid_i = 0; s_wvalid_i = 0;
      tick();
      chk("t1_cyc", wb_cyc_o, 1);
      chk("t1_stb", wb_stb_o, 1);
      chk("t1_we", wb_we_o, 1);
      chk("t1_adr", wb_adr_o, 32'h10);
      chk("t1_dat", wb_dat_o, 32'hDEADBEEF);
      chk("t1_sel", wb_sel_o, 4'hF);
      chk("t1_awready_freed", s_awready_o, 1);
      tick();
      chk("t1_stb_dropped", wb_stb_o, 0);
      chk("t1_cyc_held", wb_cyc_o, 1);
      wb_ack_i = 1;
      tick();
      wb_ack_i = 0;
      chk("t1_cyc_end", wb_cyc_o, 0);
      chk("t1_bvalid", s_bvalid_o, 1);
      chk("t1_bresp", s_bresp_o, 2'b00);
      tick();
      chk("t1_bvalid_hold", s_bvalid_o, 1);
      s_bready_i = 1;
      tick();
      s_bready_i = 0;
      chk("t1_bvalid_clr", s_bvalid_o, 0);

      // T2: W five cycles before AW
      s_wvalid_i = 1; s_wdata_i = 32'h1234; s_wstrb_i = 4'h3;
      tick();
      s_wvalid_i = 0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t2_no_cyc_wait", wb_cyc_o, 0);
      end
      s_awvalid_i = 1; s_awaddr_i = 32'h20;
      tick();
      chk("t2_no_cyc_t5", wb_cyc_o, 0);
      s_awvalid_i = 0;
      tick();
      chk("t2_cyc_t6", wb_cyc_o, 1);
      chk("t2_sel", wb_sel_o, 4'h3);
      chk("t2_adr", wb_adr_o, 32'h20);
      chk("t2_dat", wb_dat_o, 32'h1234);
      wb_ack_i = 1;
      tick();
      wb_ack_i = 0;
      chk("t2_cyc_end", wb_cyc_o, 0);
      chk("t2_bvalid", s_bvalid_o, 1);
      chk("t2_bresp", s_bresp_o, 2'b00);
      s_bready_i = 1;
      tick();
      s_bready_i = 0;
      chk("t2_bvalid_clr", s_bvalid_o, 0);

      // T3: read with four stall cycles
      s_arvalid_i = 1; s_araddr_i = 32'h40; wb_stall_i = 1;
      tick();
      s_arvalid_i = 0;
      tick();
      chk("t3_cyc", wb_cyc_o, 1);
      chk("t3_we", wb_we_o, 0);
      chk("t3_sel", wb_sel_o, 4'hF);
      for (int i = 0; i < 4; i++) begin
         chk("t3_stb_stalled", wb_stb_o, 1);
         tick();
      end
      chk("t3_stb_5th", wb_stb_o, 1);
      chk("t3_adr_held", wb_adr_o, 32'h40);
      wb_stall_i = 0; wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D;
      tick();
      wb_ack_i = 0;
      chk("t3_cyc_end", wb_cyc_o, 0);
      chk("t3_rvalid", s_rvalid_o, 1);
      chk("t3_rdata", s_rdata_o, 32'hCAFEF00D);
      chk("t3_rresp", s_rresp_o, 2'b00);
      s_rready_i = 1;
      tick();
      s_rready_i = 0;
      chk("t3_rvalid_clr", s_rvalid_o, 0);

      // T4a: write never acknowledged, watchdog fires after 8 cycles
      s_awvalid_i = 1; s_awaddr_i = 32'h80;
      s_wvalid_i = 1; s_wdata_i = 32'h11; s_wstrb_i = 4'hF;
      tick();
      s_awvalid_i = 0; s_wvalid_i = 0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("t4_cyc_before_timeout", wb_cyc_o, 1);
         tick();
      end
      chk("t4_cyc_timeout", wb_cyc_o, 0);
      chk("t4_bvalid", s_bvalid_o, 1);
      chk("t4_bresp", s_bresp_o, 2'b10);
      wb_ack_i = 1;
      tick();
      wb_ack_i = 0;
      chk("t4_late_ack_bvalid", s_bvalid_o, 1);
      chk("t4_late_ack_bresp", s_bresp_o, 2'b10);
      chk("t4_late_ack_cyc", wb_cyc_o, 0);
      s_bready_i = 1;
      tick();
      s_bready_i = 0;
      chk("t4_bvalid_clr", s_bvalid_o, 0);

      // T4b: read terminated by err (ack also high, err wins)
      s_arvalid_i = 1; s_araddr_i = 32'h44;
      tick();
      s_arvalid_i = 0;
      tick();
      chk("t4_err_cyc", wb_cyc_o, 1);
      wb_ack_i = 1; wb_err_i = 1; wb_dat_i = 32'h5555;
      tick();
      wb_ack_i = 0; wb_err_i = 0;
      chk("t4_err_rvalid", s_rvalid_o, 1);
      chk("t4_err_rresp", s_rresp_o, 2'b10);
      chk("t4_err_rdata", s_rdata_o, 0);
      s_rready_i = 1;
      tick();
      s_rready_i = 0;

      // T5: simultaneous write and read pending, alternating service
      s_awvalid_i = 1; s_awaddr_i = 32'h100;
      s_wvalid_i = 1; s_wdata_i = 32'hAAAA0001; s_wstrb_i = 4'hF;
      s_arvalid_i = 1; s_araddr_i = 32'h200;
      tick();
      s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         exp_we  = (k % 2 == 0);
         exp_adr = exp_we ? 32'h100 + 32'(4 * (k / 2)) : 32'h200 + 32'(4 * (k / 2));
         chk("t5_order_we", wb_we_o, exp_we);
         chk("t5_adr", wb_adr_o, exp_adr);
         if (exp_we) chk("t5_wdat", wb_dat_o, 32'hAAAA0001 + 32'(k / 2));
         wb_ack_i = 1; wb_dat_i = 32'hA0 + 32'(k);
         if (k == 0) begin
            s_awvalid_i = 1; s_awaddr_i = 32'h104;
            s_wvalid_i = 1; s_wdata_i = 32'hAAAA0002;
         end
         if (k == 1) begin
            s_arvalid_i = 1; s_araddr_i = 32'h204;
         end
         tick();
         wb_ack_i = 0; s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
         if (exp_we) begin
            chk("t5_bvalid", s_bvalid_o, 1);
            chk("t5_bresp", s_bresp_o, 2'b00);
            s_bready_i = 1;
            tick();
            s_bready_i = 0;
            chk("t5_bvalid_clr", s_bvalid_o, 0);
         end else begin
            chk("t5_rvalid", s_rvalid_o, 1);
            chk("t5_rdata", s_rdata_o, 32'hA0 + 32'(k));
            if (k == 1) begin
               for (int j = 0; j < 3; j++) begin
                  tick();
                  chk("t5_rvalid_stable", s_rvalid_o, 1);
                  chk("t5_rdata_stable", s_rdata_o, 32'hA1);
               end
            end
            s_rready_i = 1;
            tick();
            s_rready_i = 0;
            chk("t5_rvalid_clr", s_rvalid_o, 0);
         end
      end

      // T6: reset pulse while in WB_WAIT, then a clean read
      s_awvalid_i = 1; s_awaddr_i = 32'h500;
      s_arvalid_i = 1; s_araddr_i = 32'h300;
      tick();
      s_awvalid_i = 0; s_arvalid_i = 0;
      tick();
      chk("t6_read_first", wb_we_o, 0);
      chk("t6_adr", wb_adr_o, 32'h300);
      tick();
      chk("t6_wait_cyc", wb_cyc_o, 1);
      chk("t6_wait_stb", wb_stb_o, 0);
      #2 rst_i = 1;
      #1;
      chk("t6_rst_cyc", wb_cyc_o, 0);
      chk("t6_rst_stb", wb_stb_o, 0);
      chk("t6_rst_rvalid", s_rvalid_o, 0);
      chk("t6_rst_bvalid", s_bvalid_o, 0);
      chk("t6_rst_awready", s_awready_o, 1);
      tick();
      rst_i = 0;
      tick();
      chk("t6_no_stale_cyc", wb_cyc_o, 0);
      chk("t6_no_stale_rvalid", s_rvalid_o, 0);
      s_arvalid_i = 1; s_araddr_i = 32'h304;
      tick();
      s_arvalid_i = 0;
      tick();
      chk("t6_post_cyc", wb_cyc_o, 1);
      chk("t6_post_adr", wb_adr_o, 32'h304);
      wb_ack_i = 1; wb_dat_i = 32'h77;
      tick();
      wb_ack_i = 0;
      chk("t6_post_rvalid", s_rvalid_o, 1);
      chk("t6_post_rdata", s_rdata_o, 32'h77);
      chk("t6_post_rresp", s_rresp_o, 2'b00);
      s_rready_i = 1;
      tick();
      s_rready_i = 0;
      chk("t6_post_rvalid_clr", s_rvalid_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
